// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver clocked at 16x the baud rate.
// Frame on the line: start (0), d7..d0 (MSB first), stop (1).
// Optional build macro UART_RX_MAJORITY_EN: every check point takes the
// 2-of-3 majority of the last three synchronized samples instead of a
// single sample. Undefined by default.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low (blocked while break_seen)
// START | counting to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits at each bit mid, MSB first
// STOP  | sampling stop bit mid; 1 -> done, 0 -> frame_err
module uart_receiver (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] sync_q;
    logic       rx_s;
    logic       rx_bit;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       break_seen;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], RX};
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous rx_s samples for the 2-of-3 vote
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    end

    assign rx_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign rx_bit = rx_s;
`endif

    // Receive FSM with registered outputs; done/frame_err default low so
    // they only ever pulse for one cycle and are mutually exclusive
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            data_out   <= 8'h00;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            break_seen <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= 4'd0;
                    bit_cnt  <= 3'd0;
                    if (rx_s) begin
                        break_seen <= 1'b0;
                    end else if (!break_seen) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= 4'd0;
                        if (!rx_bit) begin
                            state <= DATA;
                        end else begin
                            // false start: line went back high before mid-bit
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_reg <= {shift_reg[6:0], rx_bit};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tick_cnt <= 4'd0;
                        if (rx_bit) begin
                            data_out <= shift_reg;
                            done     <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                            break_seen <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tick_cnt   <= 4'd0;
                    bit_cnt    <= 3'd0;
                    shift_reg  <= 8'h00;
                    data_out   <= 8'h00;
                    busy       <= 1'b0;
                    break_seen <= 1'b0;
                end
            endcase
        end
    end

endmodule
